crc8_frame_ctrl: RTL and testbench

Frame-level sequencer for a bit-serial CRC-8 engine. It accepts a byte stream over a valid/ready handshake, serializes each byte MSB-first into an internal CRC-8 shift register, and reports the frame CRC after the byte flagged `in_last`. It sits between the byte-wide packet datapath and the serial CRC engine, so producers never drive per-bit shift/clear controls directly. It serves both generation (CRC of payload) and checking (payload plus received CRC, which yields zero residue).

---
 rtl/crc8_pkg.sv | 23 ++
 rtl/crc8_lfsr.sv | 27 ++
 rtl/crc8_frame_ctrl.sv | 116 +++++++++++
 tb/tb_crc8_frame_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc8_pkg.sv
// Shared types and helpers for the bit-serial CRC-8 frame controller.
// Holds the FSM state enum, default polynomial/seed and the single-bit CRC update.
package crc8_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // One MSB-first polynomial step; the x^8 term is implicit in the feedback bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                             input logic       bit_in,
                                             input logic [7:0] poly);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_lfsr.sv
// Bit-serial CRC-8 register: one polynomial step per shift, reseeded by load.
module crc8_lfsr
    import crc8_pkg::*;
#(
    parameter logic [7:0] POLY = CRC8_POLY,
    parameter logic [7:0] INIT = CRC8_INIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift,
    input  logic       load,
    input  logic       bit_in,
    output logic [7:0] crc
);

    // Reseed wins over shifting so an abort never folds in a stray bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= INIT;
        end else if (load) begin
            crc <= INIT;
        end else if (shift) begin
            crc <= crc8_step(crc, bit_in, POLY);
        end
    end

endmodule

// File: rtl/crc8_frame_ctrl.sv
// Byte-stream front end for the serial CRC-8 engine: valid/ready intake,
// MSB-first serialization, and per-frame result reporting.
module crc8_frame_ctrl
    import crc8_pkg::*;
#(
    parameter logic [7:0] POLY = CRC8_POLY,
    parameter logic [7:0] INIT = CRC8_INIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] crc_out,
    output logic       crc_valid,
    output logic       crc_ok,
    output logic       busy
);

    state_t     state;
    state_t     state_next;
    logic [7:0] byte_reg;
    logic [2:0] bit_cnt;
    logic       last_flag;
    logic [7:0] crc;
    logic [7:0] crc_final;
    logic       shift;
    logic       load;
    logic       accept;
    logic       frame_end;

    crc8_lfsr #(
        .POLY(POLY),
        .INIT(INIT)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .shift (shift),
        .load  (load),
        .bit_in(byte_reg[7]),
        .crc   (crc)
    );

    // The last bit's step is computed here so the result can be published on DONE entry.
    assign crc_final = crc8_step(crc, byte_reg[7], POLY);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        shift      = 1'b0;
        load       = 1'b0;
        accept     = 1'b0;
        frame_end  = 1'b0;
        crc_valid  = (state == DONE);
        if (clr) begin
            state_next = IDLE;
            load       = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        accept     = 1'b1;
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    shift = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = last_flag ? DONE : IDLE;
                        frame_end  = last_flag;
                    end
                end
                DONE: begin
                    load       = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            byte_reg  <= 8'h00;
            bit_cnt   <= 3'd0;
            last_flag <= 1'b0;
            crc_out   <= INIT;
            crc_ok    <= (INIT == 8'h00);
            busy      <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                byte_reg  <= in_data;
                last_flag <= in_last;
                bit_cnt   <= 3'd0;
            end else if (shift) begin
                byte_reg <= {byte_reg[6:0], 1'b0};
                bit_cnt  <= bit_cnt + 3'd1;
            end
            if (frame_end) begin
                crc_out <= crc_final;
                crc_ok  <= (crc_final == 8'h00);
            end
            if (clr || frame_end) begin
                busy <= 1'b0;
            end else if (accept) begin
                busy <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_crc8_frame_ctrl.sv
// Self-checking bench for crc8_frame_ctrl: a byte-level reference model is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_crc8_frame_ctrl;

    localparam logic [7:0] POLY = 8'h07;
    localparam logic [7:0] INIT = 8'h00;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       clr      = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last  = 1'b0;
    logic       in_ready;
    logic [7:0] crc_out;
    logic       crc_valid;
    logic       crc_ok;
    logic       busy;

    crc8_frame_ctrl #(
        .POLY(POLY),
        .INIT(INIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .crc_out  (crc_out),
        .crc_valid(crc_valid),
        .crc_ok   (crc_ok),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t      tx_q[$];
    int         dut_hs[$];
    int         compared     = 0;
    int         mismatched   = 0;
    int         cyc          = 0;
    int         last_hs_cyc  = 0;
    int         valid_pulses = 0;
    int         m_wait       = 0;
    int         m_pub        = 0;
    logic [7:0] m_crc        = INIT;
    logic [7:0] m_pend       = INIT;
    logic [7:0] m_crc_out    = INIT;
    logic [7:0] m_byte_crc   = INIT;
    logic       m_valid      = 1'b0;
    logic       m_busy       = 1'b0;
    logic       m_accept     = 1'b0;

    // Whole-byte CRC-8 (non-reflected): xor the byte in, then eight polynomial steps.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
        end
        return c;
    endfunction

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte costs 8 busy edges (9 if it closes the frame), and the
    // frame CRC appears on the 8th edge after the closing handshake.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wait    = 0;
            m_pub     = 0;
            m_crc     = INIT;
            m_crc_out = INIT;
            m_valid   = 1'b0;
            m_busy    = 1'b0;
        end else begin
            m_accept = in_valid && !clr && (m_wait == 0);
            m_valid  = 1'b0;
            if (clr) begin
                m_wait = 0;
                m_pub  = 0;
                m_crc  = INIT;
                m_busy = 1'b0;
            end else if (m_accept) begin
                m_byte_crc = crc8_byte(m_crc, in_data);
                m_busy     = 1'b1;
                if (tx_q.size() > 0) void'(tx_q.pop_front());
                if (in_last) begin
                    m_pend      = m_byte_crc;
                    m_pub       = 8;
                    m_wait      = 9;
                    m_crc       = INIT;
                    last_hs_cyc = cyc;
                end else begin
                    m_crc  = m_byte_crc;
                    m_wait = 8;
                end
            end else begin
                if (m_wait > 0) m_wait--;
                if (m_pub > 0) begin
                    m_pub--;
                    if (m_pub == 0) begin
                        m_crc_out = m_pend;
                        m_valid   = 1'b1;
                        m_busy    = 1'b0;
                    end
                end
            end
            cyc++;
        end
    end

    // Every-cycle comparison, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        check_output("in_ready", 8'(in_ready), 8'((m_wait == 0) && !clr));
        check_output("crc_valid", 8'(crc_valid), 8'(m_valid));
        check_output("crc_out", crc_out, m_crc_out);
        check_output("crc_ok", 8'(crc_ok), 8'(m_crc_out == 8'h00));
        check_output("busy", 8'(busy), 8'(m_busy));
        if (in_valid && in_ready) dut_hs.push_back(cyc);
        if (crc_valid) begin
            valid_pulses++;
            check_int("valid_latency", cyc - last_hs_cyc, 9);
        end
    end

    task automatic push_byte(input logic [7:0] data, input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        tx_q.push_back(b);
    endtask

    task automatic apply_stimulus(input int gap_pct, input int clr_pct);
        @(posedge clk);
        #1;
        clr = (int'($urandom_range(99)) < clr_pct);
        if (tx_q.size() > 0) begin
            in_valid = (int'($urandom_range(99)) >= gap_pct);
            in_data  = tx_q[0].data;
            in_last  = tx_q[0].last;
        end else begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
        end
    endtask

    task automatic run_frames(input int gap_pct, input int clr_pct, input int budget);
        int n;
        n = 0;
        while ((tx_q.size() > 0 || m_wait != 0) && n < budget) begin
            apply_stimulus(gap_pct, clr_pct);
            n++;
        end
        if (n >= budget) begin
            check_int("drain_timeout", n, -1);
            tx_q.delete();
        end
        apply_stimulus(0, 0);
        apply_stimulus(0, 0);
    endtask

    task automatic wait_accept(input int budget);
        int n;
        n = 0;
        do begin
            apply_stimulus(0, 0);
            n++;
        end while (m_wait == 0 && n < budget);
        if (m_wait == 0) check_int("accept_timeout", n, -1);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        string      s;
        int         p0;
        int         len;
        bit         append;
        logic [7:0] run_crc;
        logic [7:0] d;

        #1 rst = 1'b1;
        #2;
        check_output("rst_crc_out", crc_out, 8'h00);
        check_output("rst_crc_valid", 8'(crc_valid), 8'h00);
        check_output("rst_crc_ok", 8'(crc_ok), 8'h01);
        check_output("rst_busy", 8'(busy), 8'h00);
        check_output("rst_in_ready", 8'(in_ready), 8'h01);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] single-byte frames");
        check_output("model_pin_01", crc8_byte(INIT, 8'h01), 8'h07);
        check_output("model_pin_ff", crc8_byte(INIT, 8'hFF), 8'hF3);
        push_byte(8'h01, 1'b1);
        run_frames(0, 0, 100);
        check_output("frame_01_crc", crc_out, 8'h07);
        check_output("frame_01_ok", 8'(crc_ok), 8'h00);
        push_byte(8'hFF, 1'b1);
        run_frames(0, 0, 100);
        check_output("frame_ff_crc", crc_out, 8'hF3);

        $display("[TB] check string 123456789, valid held high");
        s = "123456789";
        dut_hs.delete();
        p0 = valid_pulses;
        for (int i = 0; i < 9; i++) push_byte(s[i], i == 8);
        run_frames(0, 0, 200);
        check_output("check_string_crc", crc_out, 8'hF4);
        check_int("check_string_pulses", valid_pulses - p0, 1);
        check_int("check_string_bytes", dut_hs.size(), 9);
        for (int i = 1; i < dut_hs.size(); i++) begin
            check_int("byte_spacing", dut_hs[i] - dut_hs[i-1], 9);
        end

        $display("[TB] check mode residue");
        push_byte(8'h01, 1'b0);
        push_byte(8'h07, 1'b1);
        run_frames(0, 0, 100);
        check_output("residue_good_crc", crc_out, 8'h00);
        check_output("residue_good_ok", 8'(crc_ok), 8'h01);
        push_byte(8'h01, 1'b0);
        push_byte(8'h06, 1'b1);
        run_frames(0, 0, 100);
        check_output("residue_bad_crc", crc_out, 8'h07);
        check_output("residue_bad_ok", 8'(crc_ok), 8'h00);

        $display("[TB] clr during 4th shift cycle");
        p0 = valid_pulses;
        push_byte(8'hAA, 1'b0);
        push_byte(8'h55, 1'b1);
        wait_accept(20);
        repeat (3) apply_stimulus(0, 0);
        clr      = 1'b1;
        in_valid = 1'b0;
        tx_q.delete();
        repeat (12) apply_stimulus(0, 0);
        check_int("clr_no_valid", valid_pulses - p0, 0);
        check_output("clr_crc_kept", crc_out, 8'h07);
        check_output("clr_busy", 8'(busy), 8'h00);
        push_byte(8'h01, 1'b1);
        run_frames(0, 0, 100);
        check_output("after_clr_crc", crc_out, 8'h07);

        $display("[TB] clr together with valid in idle");
        p0 = valid_pulses;
        apply_stimulus(0, 0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        in_last  = 1'b1;
        @(negedge clk);
        check_output("clr_idle_ready", 8'(in_ready), 8'h00);
        @(posedge clk);
        #1;
        check_output("clr_idle_busy", 8'(busy), 8'h00);
        clr      = 1'b0;
        in_valid = 1'b0;
        repeat (12) apply_stimulus(0, 0);
        check_int("clr_idle_no_valid", valid_pulses - p0, 0);

        $display("[TB] asynchronous reset mid-shift");
        push_byte(8'h3C, 1'b1);
        wait_accept(20);
        repeat (2) apply_stimulus(0, 0);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        tx_q.delete();
        #1;
        check_output("arst_crc_out", crc_out, 8'h00);
        check_output("arst_crc_valid", 8'(crc_valid), 8'h00);
        check_output("arst_crc_ok", 8'(crc_ok), 8'h01);
        check_output("arst_busy", 8'(busy), 8'h00);
        check_output("arst_in_ready", 8'(in_ready), 8'h01);
        @(posedge clk);
        #1 rst = 1'b0;
        push_byte(8'h01, 1'b1);
        run_frames(0, 0, 100);
        check_output("after_arst_crc", crc_out, 8'h07);

        $display("[TB] randomized frames");
        for (int f = 0; f < 40; f++) begin
            len     = int'($urandom_range(1, 4));
            append  = 1'($urandom_range(0, 2) == 0);
            run_crc = INIT;
            for (int b = 0; b < len; b++) begin
                d       = 8'($urandom);
                run_crc = crc8_byte(run_crc, d);
                push_byte(d, (b == len - 1) && !append);
            end
            if (append) push_byte(run_crc, 1'b1);
            run_frames(int'($urandom_range(0, 60)), (f % 4 == 3) ? 3 : 0, 400);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
